// File: rtl/bowling_lanes.sv
// Multi-lane bowling scorer: shared roll port with frame-rule validation, per-lane
// game tracking, and a frame-walk scoring FSM. Optional BOWLING_FRAME_SCORES_EN adds per-frame totals.
`timescale 1ns/1ps

module bowling_lane #(
  parameter int FRAMES = 10,
  parameter int PINS   = 10,
  parameter int DEPTH  = 21,
  parameter int PIN_W  = 4,
  parameter int FR_W   = 4,
  parameter int IDX_W  = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [PIN_W-1:0]             pin_count,
  output logic [DEPTH-1:0][PIN_W-1:0]  rolls,
  output logic                         legal,
  output logic                         game_over
);
  logic [IDX_W-1:0] widx;
  logic [FR_W-1:0]  frame;
  logic [1:0]       ball;
  logic [PIN_W-1:0] rack;   // pins already down on the current rack
  logic             bonus;  // strike/spare seen in the last frame
  logic [PIN_W:0]   sum;
  logic             last, clear;

  assign sum   = {1'b0, rack} + {1'b0, pin_count};
  assign last  = (frame == FR_W'(FRAMES-1));
  assign clear = (sum == (PIN_W+1)'(PINS));
  assign legal = !game_over && (sum <= (PIN_W+1)'(PINS));

  always_ff @(posedge clock) begin
    if (reset) begin
      rolls <= '0; widx <= '0; frame <= '0; ball <= '0;
      rack <= '0; bonus <= 1'b0; game_over <= 1'b0;
    end else if (wr) begin
      for (int k = 0; k < DEPTH; k++)
        if (widx == IDX_W'(k)) rolls[k] <= pin_count;
      widx <= widx + IDX_W'(1);
      if (!last) begin
        if (ball == 2'd0 && !clear) begin
          ball <= 2'd1;
          rack <= sum[PIN_W-1:0];
        end else begin
          ball  <= 2'd0;
          rack  <= '0;
          frame <= frame + FR_W'(1);
        end
      end else begin
        // rack is re-racked after every strike or spare in the fill frame
        rack <= clear ? '0 : sum[PIN_W-1:0];
        case (ball)
          2'd0: begin ball <= 2'd1; bonus <= clear; end
          2'd1: if (bonus || clear) ball <= 2'd2; else game_over <= 1'b1;
          default: game_over <= 1'b1;
        endcase
      end
    end
  end
endmodule

module bowling_lanes #(
  parameter  int LANES   = 2,
  parameter  int FRAMES  = 10,
  parameter  int PINS    = 10,
  parameter  int SCORE_W = 9,
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int PIN_W   = $clog2(PINS+1),
  localparam int DEPTH   = 2*FRAMES+1,
  localparam int FR_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int IDX_W   = $clog2(DEPTH+3)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               roll,
  input  logic [LANE_W-1:0]  roll_lane,
  input  logic [PIN_W-1:0]   pin_count,
  output logic               roll_error,
  input  logic               calc_start,
  input  logic [LANE_W-1:0]  calc_lane,
  output logic               busy,
  output logic               score_valid,
  output logic [LANE_W-1:0]  score_lane,
  output logic [SCORE_W-1:0] score,
`ifdef BOWLING_FRAME_SCORES_EN
  output logic               frame_valid,
  output logic [FR_W-1:0]    frame_idx,
  output logic [SCORE_W-1:0] frame_score,
`endif
  output logic [LANES-1:0]   game_over
);
  typedef enum logic [1:0] {IDLE, SCORE, DONE} state_t;

  state_t                                   state;
  logic [LANES-1:0]                         wr, lane_ok;
  logic [LANES-1:0][DEPTH-1:0][PIN_W-1:0]   rolls;
  logic [DEPTH-1:0][PIN_W-1:0]              sel_rolls;
  logic [LANE_W-1:0]                        sel;
  logic [FR_W-1:0]                          f;
  logic [IDX_W-1:0]                         p, p1, p2, p_next;
  logic [PIN_W-1:0]                         r0, r1, r2;
  logic [SCORE_W-1:0]                       acc, acc_next;
  logic                                     roll_in, calc_in, sel_ok, roll_ok, strike, spare;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wr[l] = roll_ok && (roll_lane == LANE_W'(l));
    bowling_lane #(.FRAMES(FRAMES), .PINS(PINS), .DEPTH(DEPTH), .PIN_W(PIN_W),
                   .FR_W(FR_W), .IDX_W(IDX_W)) u_lane (
      .clock(clock), .reset(reset), .wr(wr[l]), .pin_count(pin_count),
      .rolls(rolls[l]), .legal(lane_ok[l]), .game_over(game_over[l]));
  end

  assign roll_in = ({1'b0, roll_lane} < (LANE_W+1)'(LANES));
  assign calc_in = ({1'b0, calc_lane} < (LANE_W+1)'(LANES));
  // rolls are frozen from calc acceptance until busy drops
  assign roll_ok = roll && roll_in && sel_ok && (pin_count <= PIN_W'(PINS))
                   && (state == IDLE) && !busy;

  always_comb begin
    sel_ok    = 1'b0;
    sel_rolls = '0;
    for (int l = 0; l < LANES; l++) begin
      if (roll_lane == LANE_W'(l)) sel_ok    = lane_ok[l];
      if (sel == LANE_W'(l))       sel_rolls = rolls[l];
    end
  end

  assign p1 = p + IDX_W'(1);
  assign p2 = p + IDX_W'(2);

  always_comb begin
    r0 = '0; r1 = '0; r2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (p  == IDX_W'(k)) r0 = sel_rolls[k];
      if (p1 == IDX_W'(k)) r1 = sel_rolls[k];
      if (p2 == IDX_W'(k)) r2 = sel_rolls[k];
    end
    strike = (r0 == PIN_W'(PINS));
    spare  = !strike && (({1'b0, r0} + {1'b0, r1}) == (PIN_W+1)'(PINS));
    if (strike) begin
      acc_next = acc + SCORE_W'(PINS) + SCORE_W'(r1) + SCORE_W'(r2);
      p_next   = p1;
    end else if (spare) begin
      acc_next = acc + SCORE_W'(PINS) + SCORE_W'(r2);
      p_next   = p2;
    end else begin
      acc_next = acc + SCORE_W'(r0) + SCORE_W'(r1);
      p_next   = p2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE; busy <= 1'b0; roll_error <= 1'b0;
      score_valid <= 1'b0; score <= '0; score_lane <= '0;
      acc <= '0; f <= '0; p <= '0; sel <= '0;
`ifdef BOWLING_FRAME_SCORES_EN
      frame_valid <= 1'b0; frame_idx <= '0; frame_score <= '0;
`endif
    end else begin
      roll_error  <= roll && !roll_ok;
      score_valid <= 1'b0;
      // lags the state by one edge, so busy spans edge 1 .. edge FRAMES+2
      busy        <= (state != IDLE);
`ifdef BOWLING_FRAME_SCORES_EN
      frame_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (calc_start && !roll && calc_in) begin
          acc <= '0; f <= '0; p <= '0; sel <= calc_lane;
          state <= SCORE;
        end
        SCORE: begin
          acc <= acc_next;
          p   <= p_next;
          f   <= f + FR_W'(1);
`ifdef BOWLING_FRAME_SCORES_EN
          frame_valid <= 1'b1;
          frame_idx   <= f;
          frame_score <= acc_next;
`endif
          if (f == FR_W'(FRAMES-1)) state <= DONE;
        end
        DONE: begin
          score       <= acc;
          score_lane  <= sel;
          score_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bowling_lanes.sv
// Directed bench for bowling_lanes: scenario tasks with hand-computed expectations.
`timescale 1ns/1ps

module tb_bowling_lanes;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       roll = 1'b0;
  logic [0:0] roll_lane = '0;
  logic [3:0] pin_count = '0;
  logic       roll_error;
  logic       calc_start = 1'b0;
  logic [0:0] calc_lane = '0;
  logic       busy, score_valid;
  logic [0:0] score_lane;
  logic [8:0] score;
  logic [1:0] game_over;
`ifdef BOWLING_FRAME_SCORES_EN
  logic       frame_valid;
  logic [3:0] frame_idx;
  logic [8:0] frame_score;
`endif

  int tests = 0;
  int fails = 0;

  bowling_lanes dut (
    .clock(clock), .reset(reset), .roll(roll), .roll_lane(roll_lane),
    .pin_count(pin_count), .roll_error(roll_error), .calc_start(calc_start),
    .calc_lane(calc_lane), .busy(busy), .score_valid(score_valid),
    .score_lane(score_lane), .score(score),
`ifdef BOWLING_FRAME_SCORES_EN
    .frame_valid(frame_valid), .frame_idx(frame_idx), .frame_score(frame_score),
`endif
    .game_over(game_over));

  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); reset = 1'b0;
  endtask

  task automatic do_roll(input int lane, input int pins, output logic err);
    @(negedge clock);
    roll = 1'b1; roll_lane = 1'(lane); pin_count = 4'(pins);
    @(negedge clock);
    err = roll_error; roll = 1'b0;
  endtask

  task automatic do_score(input int lane, output logic [8:0] val, output int cyc);
    @(negedge clock); calc_start = 1'b1; calc_lane = 1'(lane);
    @(negedge clock); calc_start = 1'b0; cyc = 0;
    while (score_valid !== 1'b1 && cyc < 40) begin @(negedge clock); cyc++; end
    val = score;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if ({score_valid, busy, roll_error, score_lane, game_over} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got %b want 000000", {score_valid, busy, roll_error, score_lane, game_over}); end
    tests++; if (score !== 9'd0) begin fails++; $display("FAIL reset_score got %0d want 0", score); end
  endtask

  task automatic test_perfect();
    logic err; logic any = 1'b0; logic [8:0] v; int c;
    do_reset();
    for (int i = 0; i < 11; i++) begin do_roll(0, 10, err); any |= err; end
    tests++; if (game_over !== 2'b00) begin fails++; $display("FAIL perfect_go11 got %b want 00", game_over); end
    do_roll(0, 10, err); any |= err;
    tests++; if (any !== 1'b0) begin fails++; $display("FAIL perfect_err got %b want 0", any); end
    tests++; if (game_over !== 2'b01) begin fails++; $display("FAIL perfect_go got %b want 01", game_over); end
    do_score(0, v, c);
    tests++; if (v !== 9'd300) begin fails++; $display("FAIL perfect_score got %0d want 300", v); end
    tests++; if (c !== 11) begin fails++; $display("FAIL perfect_latency got %0d want 11", c); end
  endtask

  task automatic test_spares();
    logic err; logic any = 1'b0; logic [8:0] v; int c;
    do_reset();
    for (int i = 0; i < 21; i++) begin do_roll(1, 5, err); any |= err; end
    tests++; if (any !== 1'b0) begin fails++; $display("FAIL spares_err got %b want 0", any); end
    tests++; if (game_over !== 2'b10) begin fails++; $display("FAIL spares_go got %b want 10", game_over); end
    do_score(1, v, c);
    tests++; if (v !== 9'd150 || score_lane !== 1'b1) begin
      fails++; $display("FAIL spares_score got %0d/lane %0d want 150/lane 1", v, score_lane); end
    do_score(0, v, c);
    tests++; if (v !== 9'd0 || score_lane !== 1'b0) begin
      fails++; $display("FAIL spares_lane0 got %0d/lane %0d want 0/lane 0", v, score_lane); end
  endtask

  task automatic test_illegal();
    logic e0, e1, e2, e3; logic [8:0] v; int c;
    do_reset();
    do_roll(0, 7, e0);
    do_roll(0, 5, e1);
    tests++; if (e1 !== 1'b1) begin fails++; $display("FAIL illegal_err got %b want 1", e1); end
    @(negedge clock);
    tests++; if (roll_error !== 1'b0) begin fails++; $display("FAIL illegal_pulse got %b want 0", roll_error); end
    do_roll(0, 3, e2);
    do_roll(0, 4, e3);
    tests++; if ({e0, e2, e3} !== 3'b000) begin fails++; $display("FAIL illegal_accept got %b want 000", {e0, e2, e3}); end
    do_roll(0, 0, e3);
    do_score(0, v, c);
    tests++; if (v !== 9'd18) begin fails++; $display("FAIL illegal_score got %0d want 18", v); end
  endtask

  task automatic test_tenth_fill();
    logic err; logic any = 1'b0; logic [8:0] v; int c;
    do_reset();
    do_roll(1, 11, err);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL pins_over got %b want 1", err); end
    for (int i = 0; i < 18; i++) begin do_roll(1, 0, err); any |= err; end
    do_roll(1, 10, err); any |= err;
    do_roll(1, 7, err);  any |= err;
    do_roll(1, 5, err);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL tenth_rack got %b want 1", err); end
    do_roll(1, 3, err); any |= err;
    tests++; if (any !== 1'b0 || game_over !== 2'b10) begin
      fails++; $display("FAIL tenth_fill got err %b go %b want 0 10", any, game_over); end
    do_score(1, v, c);
    tests++; if (v !== 9'd20) begin fails++; $display("FAIL tenth_score got %0d want 20", v); end
  endtask

  task automatic test_game_over();
    logic err; logic [8:0] v; int c;
    do_reset();
    for (int i = 0; i < 19; i++) do_roll(0, (i % 2 == 0) ? 3 : 4, err);
    tests++; if (game_over !== 2'b00) begin fails++; $display("FAIL go_early got %b want 00", game_over); end
    do_roll(0, 4, err);
    tests++; if (game_over !== 2'b01) begin fails++; $display("FAIL go_set got %b want 01", game_over); end
    do_roll(0, 2, err);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL go_extra got %b want 1", err); end
    do_score(0, v, c);
    tests++; if (v !== 9'd70) begin fails++; $display("FAIL go_score got %0d want 70", v); end
  endtask

  task automatic test_back_to_back();
    logic err; logic any = 1'b0; logic [8:0] v; int c;
    do_reset();
    for (int i = 0; i < 10; i++) begin do_roll(i % 2, 1, err); any |= err; end
    @(negedge clock); calc_start = 1'b1; calc_lane = 1'b0;
    @(negedge clock); calc_start = 1'b0;
    do_roll(1, 1, err);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL busy_roll got %b want 1", err); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_high got %b want 1", busy); end
    c = 0;
    while (score_valid !== 1'b1 && c < 40) begin @(negedge clock); c++; end
    tests++; if (score !== 9'd5) begin fails++; $display("FAIL busy_partial got %0d want 5", score); end
    c = 0;
    while (busy !== 1'b0 && c < 10) begin @(negedge clock); c++; end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_drop got %b want 0", busy); end
    for (int i = 10; i < 40; i++) begin do_roll(i % 2, 1, err); any |= err; end
    tests++; if (any !== 1'b0 || game_over !== 2'b11) begin
      fails++; $display("FAIL inter_rolls got err %b go %b want 0 11", any, game_over); end
    do_score(0, v, c);
    tests++; if (v !== 9'd20) begin fails++; $display("FAIL inter_lane0 got %0d want 20", v); end
    do_score(1, v, c);
    tests++; if (v !== 9'd20) begin fails++; $display("FAIL inter_lane1 got %0d want 20", v); end
  endtask

  task automatic test_reset_mid_score();
    logic err; logic seen = 1'b0; logic [8:0] v; int c;
    do_reset();
    for (int i = 0; i < 12; i++) do_roll(1, 10, err);
    @(negedge clock); calc_start = 1'b1; calc_lane = 1'b1;
    @(negedge clock); calc_start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    tests++; if ({score_valid, busy, roll_error, game_over} !== 5'b0 || score !== 9'd0) begin
      fails++; $display("FAIL midreset_out got %b score %0d want 00000 score 0",
                        {score_valid, busy, roll_error, game_over}, score); end
    for (int i = 0; i < 15; i++) begin @(negedge clock); seen |= score_valid; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b want 0", seen); end
    for (int i = 0; i < 20; i++) do_roll(1, (i % 2 == 0) ? 9 : 0, err);
    do_score(1, v, c);
    tests++; if (v !== 9'd90) begin fails++; $display("FAIL midreset_fresh got %0d want 90", v); end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_spares();
    test_illegal();
    test_tenth_fill();
    test_game_over();
    test_back_to_back();
    test_reset_mid_score();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
